// File: rtl/overlap.sv
// Overlap-add of two 4x16 signed PCM frames with lane-wise saturation.
// One-cycle result latency; no backpressure: loads and actions are accepted every edge.
module overlap (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        action,
    inout  wire  [63:0] dataBus,
    output logic [63:0] dataBusOut
);

    logic [3:0][15:0] frame_a;
    logic [3:0][15:0] frame_b;
    logic             loaded_first;
    logic [63:0]      result_q;
    logic [63:0]      sum_dat;

    // The two top bits of the 17-bit sum disagree exactly when the lane overflowed.
    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        case (s[16:15])
            2'b01:   return 16'h7fff;
            2'b10:   return 16'h8000;
            default: return s[15:0];
        endcase
    endfunction

    always_comb begin
        sum_dat = '0;
        for (int i = 0; i < 4; i++) begin
            sum_dat[i*16 +: 16] = sat16(frame_a[i], frame_b[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_a      <= '0;
            frame_b      <= '0;
            loaded_first <= 1'b0;
            result_q     <= '0;
        end else if (action) begin
            // The DUT owns the bus during an action, so a concurrent load is dropped.
            result_q     <= sum_dat;
            loaded_first <= 1'b0;
        end else if (load) begin
            if (!loaded_first) begin
                frame_a      <= dataBus;
                frame_b      <= '0;
                loaded_first <= 1'b1;
            end else begin
                frame_b      <= dataBus;
                loaded_first <= 1'b0;
            end
        end
    end

    assign dataBusOut = result_q;
    assign dataBus    = action ? result_q : 64'bz;

endmodule

// File: tb/tb_overlap.sv
// Directed and random stimulus for overlap, checked against a frame/pointer model
// with a queue of pending results popped one edge after each action.
module tb_overlap;

    logic        clock;
    logic        reset;
    logic        load;
    logic        action;
    logic [63:0] tb_dat;
    logic        tb_en;
    wire  [63:0] dataBus;
    logic [63:0] dataBusOut;

    int checks = 0;
    int errors = 0;

    logic [63:0] ma = '0;
    logic [63:0] mb = '0;
    logic        mptr = 1'b0;
    logic [63:0] mres = '0;
    logic [63:0] q[$];

    assign dataBus = tb_en ? tb_dat : 64'bz;

    overlap dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .action     (action),
        .dataBus    (dataBus),
        .dataBusOut (dataBusOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] pack(input int s3, input int s2, input int s1, input int s0);
        return {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
    endfunction

    function automatic logic [63:0] ola(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        int x;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            x = int'($signed(a[i*16 +: 16])) + int'($signed(b[i*16 +: 16]));
            if (x > 32767)  x = 32767;
            if (x < -32768) x = -32768;
            r[i*16 +: 16] = 16'(x);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic a, input logic [63:0] d);
        @(negedge clock);
        reset  = r;
        load   = l;
        action = a;
        tb_dat = d;
        tb_en  = !a;
        if (r) begin
            ma = '0; mb = '0; mptr = 1'b0; mres = '0;
            q.delete();
        end else if (a) begin
            q.push_back(ola(ma, mb));
            mptr = 1'b0;
        end else if (l) begin
            if (!mptr) begin
                ma = d; mb = '0; mptr = 1'b1;
            end else begin
                mb = d; mptr = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        if (!r && a) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_empty observed=%0d expected=%0d", 0, 1);
            end else begin
                mres = q.pop_front();
            end
        end
        check("dataBusOut", dataBusOut, mres);
        if (a) check("dataBus_drive", dataBus, mres);
        else   check("dataBus_release", dataBus, d);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; action = 1'b0; tb_dat = '0; tb_en = 1'b0;

        // Reset, then an action with nothing loaded
        step(1, 0, 0, 64'h0);
        check("reset_zero", dataBusOut, 64'h0);
        step(0, 0, 1, 64'h0);
        check("empty_action", dataBusOut, 64'h0);

        // Basic pair, repeated action keeps the same result on both outputs
        step(0, 1, 0, pack(4, 3, 2, 1));
        step(0, 1, 0, pack(40, 30, 20, 10));
        step(0, 0, 1, 64'h0);
        check("basic_pair", dataBusOut, pack(44, 33, 22, 11));
        step(0, 0, 1, 64'h0);
        check("basic_repeat_bus", dataBus, pack(44, 33, 22, 11));

        // Single load passes A through
        step(0, 1, 0, pack(-5, 7, -100, 300));
        step(0, 0, 1, 64'h0);
        check("single_load", dataBusOut, pack(-5, 7, -100, 300));

        // Saturation at both rails, cancellation, and exact limits
        step(0, 1, 0, pack(32767, -1, -30000, 30000));
        step(0, 1, 0, pack(0, 1, -10000, 10000));
        step(0, 0, 1, 64'h0);
        check("saturate_a", dataBusOut, pack(32767, 0, -32768, 32767));
        step(0, 1, 0, pack(-32768, 32767, -32768, 100));
        step(0, 1, 0, pack(-1, 32767, 0, -200));
        step(0, 0, 1, 64'h0);
        check("saturate_b", dataBusOut, pack(-32768, 32767, -32768, -100));

        // Pointer cleared by action: next single load lands in A with B cleared
        step(0, 1, 0, pack(1, 2, 3, 4));
        step(0, 1, 0, pack(5, 6, 7, 8));
        step(0, 0, 1, 64'h0);
        step(0, 1, 0, pack(100, 200, 300, 400));
        step(0, 0, 1, 64'h0);
        check("pointer_reset", dataBusOut, pack(100, 200, 300, 400));

        // Third load starts a new pair
        step(0, 1, 0, pack(9, 9, 9, 9));
        step(0, 1, 0, pack(8, 8, 8, 8));
        step(0, 1, 0, pack(-7, 6, -5, 4));
        step(0, 0, 1, 64'h0);
        check("third_load", dataBusOut, pack(-7, 6, -5, 4));

        // Load with action: load ignored, pointer cleared
        step(0, 1, 0, pack(10, 20, 30, 40));
        step(0, 1, 0, pack(1, 1, 1, 1));
        step(0, 1, 1, 64'h0);
        check("load_action", dataBusOut, pack(11, 21, 31, 41));
        step(0, 1, 0, pack(2, 2, 2, 2));
        step(0, 0, 1, 64'h0);
        check("after_load_action", dataBusOut, pack(2, 2, 2, 2));

        // Bus released when idle: driving the complement must read back cleanly
        step(0, 0, 0, ~mres);
        step(0, 1, 0, ~mres);

        // Reset mid-pair discards the half-loaded pair
        step(0, 1, 0, pack(123, 456, 789, 1000));
        step(1, 0, 0, 64'h0);
        step(0, 0, 1, 64'h0);
        check("reset_mid_pair", dataBusOut, 64'h0);

        for (int i = 0; i < 300; i++) begin
            logic [63:0] rd;
            int sel;
            rd  = {$urandom(), $urandom()};
            sel = $urandom_range(0, 19);
            if (sel == 0)      step(1, 0, 0, rd);
            else if (sel < 8)  step(0, 0, 1, rd);
            else if (sel < 10) step(0, 1, 1, rd);
            else if (sel < 18) step(0, 1, 0, rd);
            else               step(0, 0, 0, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/overlap.md
# overlap

Overlap-add stage for a PCM audio decoder datapath. It holds two consecutive 64-bit frames, each four signed 16-bit samples, arriving on a shared data bus. On command it outputs the lane-wise saturated sum of the two frames. It sits between the inverse-transform/windowing stage, which loads frames, and the PCM output stage, which consumes the summed samples.

## Interface
- No parameters. Lane width is 16 bits and lane count is 4; both are fixed.
- One clock; reset is synchronous and active-high.
- `clock`  input  1: sole clock; all state updates on its rising edge.
- `reset`  input  1: synchronous, active-high; clears all state.
- `load`  input  1: capture `dataBus` into the next frame buffer this edge.
- `action`  input  1: compute and present the overlap sum this edge.
- `dataBus`  inout  64: frame input, lanes {s3,s2,s1,s0}; s0 = [15:0], s1 = [31:16], s2 = [47:32], s3 = [63:48], each two's complement.
  - DUT drives the registered result onto it while `action`=1.
  - DUT drives high-Z otherwise.
- `dataBusOut`  output  64: registered overlap sum, same lane layout.

## Operation
- State:
  - frame buffers A and B, 4×16 signed each;
  - 1-bit `loadedFirst` pointer;
  - 64-bit result register.
- Load, when `load`=1 and `action`=0:
  - `loadedFirst`=0: A ← dataBus; B ← 0; `loadedFirst` ← 1.
  - `loadedFirst`=1: B ← dataBus; `loadedFirst` ← 0.
- Action, when `action`=1:
  - For each lane i, result[i] ← sat16(A[i] + B[i]). The sum is computed at 17 bits, then clamped to [-32768, 32767].
  - `loadedFirst` ← 0, so the next load starts a new pair into A.
  - A and B are kept, so repeated actions give the same result.
- `load`=1 with `action`=1: action wins and the load is ignored, because the bus is owned by the DUT in this case.
- If `action` is asserted after only one load since the last action (B = 0), the result is A saturated, which equals A.
- Neither asserted: all state holds.
- Bus direction: `dataBus` = `action` ? result register : 64'bz. This is a combinational enable on the registered value. The external driver must release the bus while `action`=1.

## Timing
- Reset, any edge with `reset`=1:
  - A, B, result ← 0; `loadedFirst` ← 0; `dataBusOut` = 0.
  - Reset has priority over `load` and `action`.
  - Reset mid-pair discards a half-loaded pair.
- Load latency: data present at edge N is stored at edge N and usable by an action at edge N+1 or later.
- Action latency: 1 cycle. The action at edge N updates `dataBusOut` after edge N, so it is sampled correct at edge N+1.
- `dataBusOut` holds its value until the next action or reset.
- Back-to-back loads on consecutive edges are allowed, with no stall or handshake.
- A third load without an intervening action overwrites A, clears B, and starts a new pair.

## Test plan
- Reset: assert `reset` one cycle -> `dataBusOut`=0; next action with no loads -> all lanes 0.
- Basic pair:
  - load {4,3,2,1}, then load {40,30,20,10}, then action.
  - Next edge: lanes s0..s3 = 11, 22, 33, 44.
  - `dataBus` shows the same value while `action`=1.
- Single load: load {-5,7,-100,300}, then action -> lanes 300, -100, 7, -5.
- Saturation and negatives:
  - Lane values A = 30000, B = 10000 -> 32767.
  - Lane values A = -30000, B = -10000 -> -32768.
  - Lane values A = -1, B = 1 -> 0.
- Pointer reset: load X, load Y, action, then load Z, action -> second result equals Z, with B cleared.
- Priority and bus:
  - `load`=1 with `action`=1: buffers unchanged and pointer cleared.
  - `dataBus` is Z whenever `action`=0.
  - Random load/action sequences are checked against a software model of A/B/pointer with 1-cycle output latency.
